// File: rtl/inert_sensor_model_if.sv
// SPI bus between the inertial interface (master) and the sensor model (slave).
interface inert_sensor_model_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/inert_sensor_model.sv
// Inertial sensor stand-in: SPI mode-3 responder with config registers,
// periodically sampled pitch-rate / Z-accel data and a data-ready interrupt.
module inert_sensor_model #(
    parameter int         SAMPLE_CYCLES = 240385,
    parameter logic [7:0] WHO_AM_I_VAL  = 8'h6A
) (
    input  logic                clk,
    input  logic                rst_n,
    inert_sensor_model_if.slave spi,
    output logic                INT,
    input  logic [15:0]         ptch_rt_in,
    input  logic [15:0]         AZ_in
);
    localparam int            TW         = $clog2(SAMPLE_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_CYCLES - 1);

    logic [2:0]    ss_pipe;
    logic [2:0]    sclk_pipe;
    logic [1:0]    mosi_pipe;
    logic [1:0]    sync_fill;
    logic          armed;
    logic          ss_fall;
    logic          ss_rise;
    logic          sclk_rise;
    logic          sclk_fall;
    logic          mosi;

    logic          frame_active;
    logic [15:0]   rx;
    logic [4:0]    bit_cnt;
    logic [7:0]    tx;
    logic          miso;

    logic [7:0]    int_ctrl;
    logic [7:0]    ctrl1_xl;
    logic [7:0]    ctrl2_g;
    logic [7:0]    ctrl5;
    logic [15:0]   ptch;
    logic [15:0]   az;
    logic [TW-1:0] timer;
    logic          pending;

    logic [6:0]    rd_addr;
    logic [7:0]    rd_data;
    logic          addr_done;
    logic          int_clear;
    logic          sample_en;
    logic          tick;
    logic          frame_busy;
    logic          capture;

    assign spi.MISO = miso;

    // A select held low across reset release must not open a frame, so falls
    // are only honoured once a genuine high has passed through the synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_pipe   <= 3'b111;
            sclk_pipe <= 3'b111;
            mosi_pipe <= 2'b00;
            sync_fill <= 2'd0;
            armed     <= 1'b0;
        end else begin
            ss_pipe   <= {ss_pipe[1:0], spi.SS_n};
            sclk_pipe <= {sclk_pipe[1:0], spi.SCLK};
            mosi_pipe <= {mosi_pipe[0], spi.MOSI};
            if (sync_fill != 2'd2)
                sync_fill <= sync_fill + 2'd1;
            if (sync_fill == 2'd2 && ss_pipe[1])
                armed <= 1'b1;
        end
    end

    assign ss_fall   = armed & ss_pipe[2] & ~ss_pipe[1];
    assign ss_rise   = ss_pipe[1] & ~ss_pipe[2];
    assign sclk_rise = sclk_pipe[1] & ~sclk_pipe[2];
    assign sclk_fall = sclk_pipe[2] & ~sclk_pipe[1];
    assign mosi      = mosi_pipe[1];

    // Address byte completes on the 8th rise; rx still lacks the bit arriving now.
    always_comb begin
        rd_addr = {rx[5:0], mosi};
        rd_data = 8'h00;
        case (rd_addr)
            7'h0D:   rd_data = int_ctrl;
            7'h0F:   rd_data = WHO_AM_I_VAL;
            7'h10:   rd_data = ctrl1_xl;
            7'h11:   rd_data = ctrl2_g;
            7'h14:   rd_data = ctrl5;
            7'h22:   rd_data = ptch[7:0];
            7'h23:   rd_data = ptch[15:8];
            7'h2C:   rd_data = az[7:0];
            7'h2D:   rd_data = az[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    assign addr_done  = frame_active & sclk_rise & (bit_cnt == 5'd7);
    assign int_clear  = addr_done & rx[6] & (rd_addr == 7'h22);
    assign sample_en  = int_ctrl[1] & (|ctrl1_xl) & (|ctrl2_g);
    assign tick       = sample_en & (timer == TIMER_LAST);
    assign frame_busy = frame_active & ~ss_rise;
    assign capture    = sample_en & (tick | pending) & ~frame_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_active <= 1'b0;
            rx           <= 16'h0000;
            bit_cnt      <= 5'd0;
            tx           <= 8'h00;
            miso         <= 1'b0;
            int_ctrl     <= 8'h00;
            ctrl1_xl     <= 8'h00;
            ctrl2_g      <= 8'h00;
            ctrl5        <= 8'h00;
        end else if (ss_fall) begin
            frame_active <= 1'b1;
            rx           <= 16'h0000;
            bit_cnt      <= 5'd0;
            miso         <= 1'b0;
        end else if (ss_rise) begin
            frame_active <= 1'b0;
            miso         <= 1'b0;
            if (frame_active && bit_cnt == 5'd16 && !rx[15]) begin
                case (rx[14:8])
                    7'h0D:   int_ctrl <= rx[7:0];
                    7'h10:   ctrl1_xl <= rx[7:0];
                    7'h11:   ctrl2_g  <= rx[7:0];
                    7'h14:   ctrl5    <= rx[7:0];
                    default: ;
                endcase
            end
        end else if (frame_active) begin
            if (sclk_rise) begin
                rx <= {rx[14:0], mosi};
                if (bit_cnt != 5'd16)
                    bit_cnt <= bit_cnt + 5'd1;
                if (addr_done && rx[6])
                    tx <= rd_data;
            end else if (sclk_fall && bit_cnt >= 5'd8 && bit_cnt != 5'd16) begin
                miso <= tx[7];
                tx   <= {tx[6:0], 1'b0};
            end
        end
    end

    // A tick inside a frame is parked in pending and applied as the frame closes,
    // so data bytes never change under an in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer   <= '0;
            pending <= 1'b0;
            INT     <= 1'b0;
            ptch    <= 16'h0000;
            az      <= 16'h0000;
        end else if (!sample_en) begin
            timer   <= '0;
            pending <= 1'b0;
            INT     <= 1'b0;
        end else begin
            timer <= tick ? '0 : timer + TW'(1);
            if (capture) begin
                ptch    <= ptch_rt_in;
                az      <= AZ_in;
                pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
            end
            if (int_clear)
                INT <= 1'b0;
            else if (capture)
                INT <= 1'b1;
        end
    end
endmodule

// File: tb/tb_inert_sensor_model.sv
// Self-checking bench for inert_sensor_model: drives SPI frames as a mode-3 master
// and compares readback against a register-map model held in the bench.
module tb_inert_sensor_model;
    localparam int         SAMPLE_CYCLES = 1000;
    localparam logic [7:0] WHO           = 8'h6A;
    localparam int         HALF          = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        INT;
    logic [15:0] ptch_rt_in;
    logic [15:0] AZ_in;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  mdl [128];

    inert_sensor_model_if spi_bus ();

    inert_sensor_model #(
        .SAMPLE_CYCLES(SAMPLE_CYCLES),
        .WHO_AM_I_VAL (WHO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi       (spi_bus),
        .INT       (INT),
        .ptch_rt_in(ptch_rt_in),
        .AZ_in     (AZ_in)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached before end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int a = 0; a < 128; a++) mdl[a] = 8'h00;
        mdl[7'h0F] = WHO;
    endtask

    function automatic bit writable(input logic [6:0] a);
        return a inside {7'h0D, 7'h10, 7'h11, 7'h14};
    endfunction

    function automatic logic [6:0] pick_addr();
        case ($urandom_range(0, 9))
            0: return 7'h0F;
            1: return 7'h10;
            2: return 7'h11;
            3: return 7'h14;
            4: return 7'h22;
            5: return 7'h23;
            6: return 7'h2C;
            7: return 7'h2D;
            default: return 7'($urandom_range(0, 127));
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(4);
        model_reset();
    endtask

    // One frame of nrises SCLK cycles; returns MISO bits sampled on each rise,
    // INT seen at the end of rise 8 and INT just before SS_n is released.
    task automatic spi_frame(input logic [15:0] word, input int nrises,
                             output logic [15:0] rx, output logic int_r8,
                             output logic int_end);
        rx     = 16'h0000;
        int_r8 = INT;
        spi_bus.SS_n = 1'b0;
        idle(HALF);
        for (int i = 0; i < nrises; i++) begin
            spi_bus.SCLK = 1'b0;
            spi_bus.MOSI = word[15-i];
            idle(HALF);
            spi_bus.SCLK = 1'b1;
            rx = {rx[14:0], spi_bus.MISO};
            idle(HALF);
            if (i == 7) int_r8 = INT;
        end
        int_end = INT;
        spi_bus.SS_n = 1'b1;
    endtask

    task automatic spi_xfer(input logic [15:0] word, input int nrises,
                            output logic [15:0] rx, output logic int_r8);
        logic int_end;
        spi_frame(word, nrises, rx, int_r8, int_end);
        idle(8);
    endtask

    task automatic test_reset();
        logic [15:0] rx;
        logic        r8;
        rst_n = 1'b0;
        idle(2);
        n_checks++;
        if (spi_bus.MISO !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_miso: got %b, expected 0", spi_bus.MISO);
        end
        n_checks++;
        if (INT !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_int: got %b, expected 0", INT);
        end
        rst_n = 1'b1;
        idle(4);
        model_reset();
        spi_xfer(16'h8F00, 16, rx, r8);
        n_checks++;
        if (rx !== {8'h00, WHO}) begin
            n_fail++;
            $display("[TB] FAIL who_am_i: got %h, expected %h", rx, {8'h00, WHO});
        end
        n_checks++;
        if (INT !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL int_unconfigured: got %b, expected 0", INT);
        end
    endtask

    // INT_CTRL is left alone so sampling stays off and data registers stay 0.
    task automatic test_random_regs();
        logic [15:0] rx;
        logic        r8;
        logic [6:0]  addr;
        logic        rw;
        logic [7:0]  data;
        int          nr;
        for (int t = 0; t < 40; t++) begin
            addr = pick_addr();
            if (addr == 7'h0D) addr = 7'h10;
            rw   = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            nr   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 16;
            spi_xfer({rw, addr, data}, nr, rx, r8);
            if (nr == 16 && !rw && writable(addr)) mdl[addr] = data;
            if (nr == 16 && rw) begin
                n_checks++;
                if (rx !== {8'h00, mdl[addr]}) begin
                    n_fail++;
                    $display("[TB] FAIL rand_read[%0d] addr %h: got %h, expected %h",
                             t, addr, rx, {8'h00, mdl[addr]});
                end
            end
        end
        n_checks++;
        if (INT !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rand_int_idle: got %b, expected 0", INT);
        end
    endtask

    task automatic test_config_and_int();
        logic [15:0] rx;
        logic        r8;
        int          waited;
        do_reset();
        ptch_rt_in = 16'h1234;
        AZ_in      = 16'hFEDC;
        spi_xfer(16'h0D02, 16, rx, r8);
        spi_xfer(16'h1053, 16, rx, r8);
        spi_xfer(16'h9000, 16, rx, r8);
        n_checks++;
        if (rx !== 16'h0053) begin
            n_fail++;
            $display("[TB] FAIL ctrl1_readback: got %h, expected 0053", rx);
        end
        spi_xfer(16'h1150, 16, rx, r8);
        idle(970);
        n_checks++;
        if (INT !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL int_early: got %b, expected 0", INT);
        end
        waited = 970;
        while (INT !== 1'b1 && waited < 1010) begin
            idle(1);
            waited++;
        end
        n_checks++;
        if (INT !== 1'b1 || waited < 990 || waited > 1005) begin
            n_fail++;
            $display("[TB] FAIL int_period: got INT=%b after %0d clks, expected 1 within 990..1005",
                     INT, waited);
        end
    endtask

    task automatic test_data_read();
        logic [15:0] rx;
        logic        r8;
        n_checks++;
        if (INT !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL int_before_read: got %b, expected 1", INT);
        end
        spi_xfer(16'hA200, 16, rx, r8);
        n_checks++;
        if (rx !== 16'h0034) begin
            n_fail++;
            $display("[TB] FAIL ptch_l: got %h, expected 0034", rx);
        end
        n_checks++;
        if (r8 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL int_clear_rise8: got %b, expected 0", r8);
        end
        spi_xfer(16'hA300, 16, rx, r8);
        n_checks++;
        if (rx !== 16'h0012) begin
            n_fail++;
            $display("[TB] FAIL ptch_h: got %h, expected 0012", rx);
        end
        spi_xfer(16'hAC00, 16, rx, r8);
        n_checks++;
        if (rx !== 16'h00DC) begin
            n_fail++;
            $display("[TB] FAIL az_l: got %h, expected 00dc", rx);
        end
        spi_xfer(16'hAD00, 16, rx, r8);
        n_checks++;
        if (rx !== 16'h00FE) begin
            n_fail++;
            $display("[TB] FAIL az_h: got %h, expected 00fe", rx);
        end
    endtask

    task automatic test_partial_write();
        logic [15:0] rx;
        logic        r8;
        spi_xfer(16'h1000, 10, rx, r8);
        spi_xfer(16'h9000, 16, rx, r8);
        n_checks++;
        if (rx !== 16'h0053) begin
            n_fail++;
            $display("[TB] FAIL partial_write: got %h, expected 0053", rx);
        end
        spi_xfer(16'h9100, 16, rx, r8);
        n_checks++;
        if (rx !== 16'h0050) begin
            n_fail++;
            $display("[TB] FAIL ctrl2_readback: got %h, expected 0050", rx);
        end
    endtask

    // Re-enabling restarts the timer, placing the next tick ~40 clks into a read.
    task automatic test_tick_mid_read();
        logic [15:0] rx;
        logic        r8;
        logic        int_end;
        int          k;
        spi_xfer(16'h0D00, 16, rx, r8);
        n_checks++;
        if (INT !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL int_disable: got %b, expected 0", INT);
        end
        spi_xfer(16'h0D02, 16, rx, r8);
        idle(954);
        ptch_rt_in = 16'hABCD;
        spi_frame(16'hA200, 16, rx, r8, int_end);
        n_checks++;
        if (rx !== 16'h0034) begin
            n_fail++;
            $display("[TB] FAIL coherent_read: got %h, expected 0034", rx);
        end
        n_checks++;
        if (int_end !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL int_deferred: got %b, expected 0", int_end);
        end
        k = 0;
        while (INT !== 1'b1 && k < 10) begin
            idle(1);
            k++;
        end
        n_checks++;
        if (INT !== 1'b1 || k < 2 || k > 4) begin
            n_fail++;
            $display("[TB] FAIL int_after_frame: got INT=%b after %0d clks, expected 1 within 2..4",
                     INT, k);
        end
        idle(8);
        spi_xfer(16'hA200, 16, rx, r8);
        n_checks++;
        if (rx !== 16'h00CD) begin
            n_fail++;
            $display("[TB] FAIL new_ptch_l: got %h, expected 00cd", rx);
        end
        spi_xfer(16'hA300, 16, rx, r8);
        n_checks++;
        if (rx !== 16'h00AB) begin
            n_fail++;
            $display("[TB] FAIL new_ptch_h: got %h, expected 00ab", rx);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] rx;
        logic        r8;
        logic [15:0] stray;
        stray = 16'h1077;
        spi_bus.SS_n = 1'b0;
        idle(HALF);
        for (int i = 0; i < 6; i++) begin
            spi_bus.SCLK = 1'b0;
            spi_bus.MOSI = 1'b0;
            idle(HALF);
            spi_bus.SCLK = 1'b1;
            idle(HALF);
        end
        spi_bus.SCLK = 1'b0;
        idle(2);
        rst_n = 1'b0;
        idle(2);
        n_checks++;
        if (spi_bus.MISO !== 1'b0 || INT !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midframe_reset_outputs: got MISO=%b INT=%b, expected 0 0",
                     spi_bus.MISO, INT);
        end
        rst_n = 1'b1;
        model_reset();
        idle(4);
        for (int i = 0; i < 16; i++) begin
            spi_bus.SCLK = 1'b0;
            spi_bus.MOSI = stray[15-i];
            idle(HALF);
            spi_bus.SCLK = 1'b1;
            idle(HALF);
        end
        spi_bus.SS_n = 1'b1;
        idle(8);
        spi_xfer(16'h9000, 16, rx, r8);
        n_checks++;
        if (rx !== {8'h00, mdl[7'h10]}) begin
            n_fail++;
            $display("[TB] FAIL ctrl1_after_reset: got %h, expected %h", rx, {8'h00, mdl[7'h10]});
        end
        spi_xfer(16'h8D00, 16, rx, r8);
        n_checks++;
        if (rx !== {8'h00, mdl[7'h0D]}) begin
            n_fail++;
            $display("[TB] FAIL int_ctrl_after_reset: got %h, expected %h", rx, {8'h00, mdl[7'h0D]});
        end
        spi_xfer(16'hA200, 16, rx, r8);
        n_checks++;
        if (rx !== {8'h00, mdl[7'h22]}) begin
            n_fail++;
            $display("[TB] FAIL data_after_reset: got %h, expected %h", rx, {8'h00, mdl[7'h22]});
        end
        spi_xfer(16'h8F00, 16, rx, r8);
        n_checks++;
        if (rx !== {8'h00, WHO}) begin
            n_fail++;
            $display("[TB] FAIL who_am_i_after_reset: got %h, expected %h", rx, {8'h00, WHO});
        end
        n_checks++;
        if (INT !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL int_after_reset: got %b, expected 0", INT);
        end
    endtask

    initial begin
        rst_n        = 1'b1;
        spi_bus.SS_n = 1'b1;
        spi_bus.SCLK = 1'b1;
        spi_bus.MOSI = 1'b0;
        ptch_rt_in   = 16'h0000;
        AZ_in        = 16'h0000;
        model_reset();
        idle(2);
        test_reset();
        test_random_regs();
        test_config_and_int();
        test_data_read();
        test_partial_write();
        test_tick_mid_read();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
